// File: rtl/axil_regfile_slave.sv
// AXI4-Lite slave register file: byte strobes, SLVERR for out-of-range indices, and valid/ready backpressure on B and R.
// Optional feature macro AXIL_WRCOUNT_EN: the last register becomes a read-only count of OKAY write commits.
module axil_regfile_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_REGS   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LSB        = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = ADDR_WIDTH - LSB;
    localparam logic [IDX_WIDTH:0] NUM_REGS_W = (IDX_WIDTH + 1)'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                  aw_full_reg;
    logic [IDX_WIDTH-1:0]  aw_idx_reg;
    logic                  w_full_reg;
    logic [DATA_WIDTH-1:0] w_data_reg;
    logic [STRB_WIDTH-1:0] w_strb_reg;
    logic                  bvalid_reg;
    logic [1:0]            bresp_reg;
    logic                  rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            rresp_reg;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic                  aw_in_range;
    logic                  ro_hit;
    logic                  wr_ok;
    logic [IDX_WIDTH-1:0]  ar_idx;
    logic                  ar_in_range;
    logic [DATA_WIDTH-1:0] read_value;
    logic [DATA_WIDTH-1:0] reg_value [NUM_REGS];

    // Sub-word address bits carry no meaning for a word-wide register file.
    generate
        if (LSB > 0) begin : g_unused
            logic unused_low_bits;
            assign unused_low_bits = ^{awaddr[LSB-1:0], araddr[LSB-1:0]};
        end
    endgenerate

    assign awready = !aw_full_reg && !rst;
    assign wready  = !w_full_reg && !rst;
    assign arready = !rvalid_reg && !rst;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    // A commit needs both halves of the write and a free B slot.
    assign commit      = aw_full_reg && w_full_reg && !bvalid_reg;
    assign aw_in_range = {1'b0, aw_idx_reg} < NUM_REGS_W;
    assign wr_ok       = aw_in_range && !ro_hit;

    assign ar_idx      = araddr[ADDR_WIDTH-1:LSB];
    assign ar_in_range = {1'b0, ar_idx} < NUM_REGS_W;

    assign bvalid = bvalid_reg;
    assign bresp  = bresp_reg;
    assign rvalid = rvalid_reg;
    assign rdata  = rdata_reg;
    assign rresp  = rresp_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full_reg <= 1'b0;
            aw_idx_reg  <= '0;
        end else if (commit) begin
            aw_full_reg <= 1'b0;
        end else if (aw_hs) begin
            aw_full_reg <= 1'b1;
            aw_idx_reg  <= awaddr[ADDR_WIDTH-1:LSB];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_full_reg <= 1'b0;
            w_data_reg <= '0;
            w_strb_reg <= '0;
        end else if (commit) begin
            w_full_reg <= 1'b0;
        end else if (w_hs) begin
            w_full_reg <= 1'b1;
            w_data_reg <= wdata;
            w_strb_reg <= wstrb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bvalid_reg <= 1'b0;
            bresp_reg  <= RESP_OKAY;
        end else if (commit) begin
            bvalid_reg <= 1'b1;
            bresp_reg  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_reg && bready) begin
            bvalid_reg <= 1'b0;
        end
    end

`ifdef AXIL_WRCOUNT_EN
    localparam int RW_REGS = NUM_REGS - 1;
    logic [DATA_WIDTH-1:0] count_reg;

    assign ro_hit = aw_idx_reg == IDX_WIDTH'(NUM_REGS - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (commit && wr_ok) begin
            count_reg <= count_reg + DATA_WIDTH'(1);
        end
    end

    assign reg_value[NUM_REGS-1] = count_reg;
`else
    localparam int RW_REGS = NUM_REGS;
    assign ro_hit = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < RW_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] value_reg;
            logic                  hit;

            assign hit = commit && wr_ok && (aw_idx_reg == IDX_WIDTH'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    value_reg <= '0;
                end else if (hit) begin
                    for (int b = 0; b < STRB_WIDTH; b++) begin
                        if (w_strb_reg[b]) begin
                            value_reg[8*b +: 8] <= w_data_reg[8*b +: 8];
                        end
                    end
                end
            end

            assign reg_value[gi] = value_reg;
        end
    endgenerate

    // Out-of-range indices match no entry and therefore read as zero.
    always_comb begin
        read_value = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_WIDTH'(i)) begin
                read_value = reg_value[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= ar_in_range ? read_value : '0;
            rresp_reg  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_reg && rready) begin
            rvalid_reg <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axil_regfile_slave.sv
// Self-checking bench for axil_regfile_slave: directed cases plus randomized traffic against a word/byte model.
// Build with AXIL_WRCOUNT_EN defined to also exercise the read-only write counter.
module tb_axil_regfile_slave;
    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int NREGS = 8;
    localparam int TMO   = 20;

    logic          clk;
    logic          rst;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [1:0]    exp_bresp = 2'b00;
    logic [DW-1:0] exp_rdata = '0;
    logic [1:0]    exp_rresp = 2'b00;

    logic [DW-1:0] model_mem [NREGS];
    logic [DW-1:0] model_cnt;

    axil_regfile_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NREGS)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [1:0] model_wresp(input logic [AW-1:0] a);
        int idx;
        idx = int'(a[AW-1:2]);
        if (idx >= NREGS) return 2'b10;
`ifdef AXIL_WRCOUNT_EN
        if (idx == NREGS - 1) return 2'b10;
`endif
        return 2'b00;
    endfunction

    task automatic model_apply(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a[AW-1:2]);
        if (model_wresp(a) == 2'b00) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
            end
`ifdef AXIL_WRCOUNT_EN
            model_cnt = model_cnt + 1;
`endif
        end
    endtask

    task automatic model_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic [1:0] r);
        int idx;
        idx = int'(a[AW-1:2]);
        d = '0;
        r = 2'b10;
        if (idx < NREGS) begin
            r = 2'b00;
            d = model_mem[idx];
`ifdef AXIL_WRCOUNT_EN
            if (idx == NREGS - 1) d = model_cnt;
`endif
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) model_mem[i] = '0;
        model_cnt = '0;
    endtask

    // ---------------- cycle-by-cycle compare ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("rst_awready", awready, 0);
            check("rst_wready", wready, 0);
            check("rst_arready", arready, 0);
            check("rst_bvalid", bvalid, 0);
            check("rst_rvalid", rvalid, 0);
        end else begin
            if (bvalid) check("bresp", bresp, exp_bresp);
            if (rvalid) begin
                check("rdata", rdata, exp_rdata);
                check("rresp", rresp, exp_rresp);
            end
        end
    end

    // ---------------- transaction tasks ----------------
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        logic aw_ok;
        logic w_ok;
        exp_bresp = model_wresp(a);
        bready = (b_dly == 0);
        tick();
        fork
            begin
                repeat (aw_dly) tick();
                awaddr = a;
                awvalid = 1'b1;
                aw_ok = 1'b0;
                for (int k = 0; k < TMO; k++) begin
                    @(negedge clk);
                    if (awready) begin
                        aw_ok = 1'b1;
                        break;
                    end
                end
                check("aw_accept", aw_ok, 1);
                tick();
                awvalid = 1'b0;
            end
            begin
                repeat (w_dly) tick();
                wdata = d;
                wstrb = s;
                wvalid = 1'b1;
                w_ok = 1'b0;
                for (int k = 0; k < TMO; k++) begin
                    @(negedge clk);
                    if (wready) begin
                        w_ok = 1'b1;
                        break;
                    end
                end
                check("w_accept", w_ok, 1);
                tick();
                wvalid = 1'b0;
            end
        join
        @(negedge clk);
        check("b_early", bvalid, 0);
        @(negedge clk);
        check("b_latency", bvalid, 1);
        resp = bresp;
        for (int k = 0; k < b_dly; k++) begin
            tick();
            @(negedge clk);
            check("b_hold", bvalid, 1);
        end
        bready = 1'b1;
        tick();
        @(negedge clk);
        check("b_done", bvalid, 0);
        model_apply(a, d, s);
        $display("WR addr=0x%02h data=0x%08h strb=0x%h bresp=%0d", a, d, s, resp);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int ar_dly, input int r_dly,
                           output logic [DW-1:0] got);
        logic ok;
        model_read(a, exp_rdata, exp_rresp);
        rready = (r_dly == 0);
        tick();
        repeat (ar_dly) tick();
        araddr = a;
        arvalid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            if (arready) begin
                ok = 1'b1;
                break;
            end
        end
        check("ar_accept", ok, 1);
        tick();
        arvalid = 1'b0;
        @(negedge clk);
        check("r_latency", rvalid, 1);
        got = rdata;
        for (int k = 0; k < r_dly; k++) begin
            tick();
            @(negedge clk);
            check("r_hold", rvalid, 1);
            check("ar_blocked", arready, 0);
        end
        rready = 1'b1;
        tick();
        @(negedge clk);
        check("r_done", rvalid, 0);
        $display("RD addr=0x%02h rdata=0x%08h rresp=%0d", a, got, rresp);
    endtask

    task automatic read_all();
        logic [DW-1:0] got;
        for (int i = 0; i < NREGS; i++) do_read(AW'(i * 4), 0, 0, got);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        awvalid = 1'b0;
        wvalid = 1'b0;
        arvalid = 1'b0;
        @(negedge clk);
        check("reset_bvalid_drop", bvalid, 0);
        check("reset_rvalid_drop", rvalid, 0);
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("release_awready", awready, 1);
        check("release_wready", wready, 1);
        check("release_arready", arready, 1);
        model_clear();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] got;
        logic [1:0]    resp;

        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0;
        araddr = '0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        model_clear();

        repeat (3) @(negedge clk);
        check("reset_rdata", rdata, 0);
        check("reset_bresp", bresp, 0);
        check("reset_rresp", rresp, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("first_awready", awready, 1);
        check("first_wready", wready, 1);
        check("first_arready", arready, 1);
        read_all();

        // Basic write then read.
        do_write(6'h08, 32'h0000_0004, 4'hF, 0, 0, 0, resp);
        check("basic_bresp", resp, 2'b00);
        do_read(6'h08, 0, 0, got);
        check("basic_rdata", got, 32'h0000_0004);

        // Byte strobes merge into the existing word.
        do_write(6'h04, 32'hAABB_CCDD, 4'hF, 0, 0, 0, resp);
        do_write(6'h04, 32'h1122_3344, 4'h5, 0, 0, 0, resp);
        do_read(6'h04, 0, 0, got);
        check("strobe_rdata", got, 32'hAA22_CC44);

        // W arrives three cycles before AW; W buffer must stay closed meanwhile.
        fork
            do_write(6'h10, 32'hCAFE_F00D, 4'hF, 3, 0, 0, resp);
            begin
                tick();
                @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("order_wready_low", wready, 0);
                end
            end
        join
        do_read(6'h10, 0, 0, got);
        check("order_rdata", got, 32'hCAFE_F00D);

        // Out-of-range index 8.
        do_write(6'h20, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, resp);
        check("oor_bresp", resp, 2'b10);
        do_read(6'h20, 0, 0, got);
        check("oor_rdata", got, 32'h0);
        check("oor_rresp", rresp, 2'b10);
        read_all();

        // Zero strobe leaves the register untouched.
        do_write(6'h08, 32'hFFFF_FFFF, 4'h0, 0, 1, 0, resp);
        check("nostrb_bresp", resp, 2'b00);
        do_read(6'h08, 0, 0, got);
        check("nostrb_rdata", got, 32'h0000_0004);

        // R backpressure.
        do_read(6'h04, 0, 5, got);
        check("rbp_rdata", got, 32'hAA22_CC44);

        // B backpressure with a second write queued behind it.
        tick();
        bready = 1'b0;
        exp_bresp = model_wresp(6'h04);
        awaddr = 6'h04; wdata = 32'h1357_9BDF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        check("bp_aw_ready", awready, 1);
        check("bp_w_ready", wready, 1);
        tick();
        awaddr = 6'h0C; wdata = 32'h2468_ACE0;
        @(negedge clk);
        check("bp_aw_full", awready, 0);
        tick();
        @(negedge clk);
        check("bp_b1_valid", bvalid, 1);
        check("bp_aw_free", awready, 1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_b1_hold", bvalid, 1);
            check("bp_aw_stall", awready, 0);
            check("bp_w_stall", wready, 0);
            tick();
        end
        bready = 1'b1;
        @(negedge clk);
        check("bp_b1_last", bvalid, 1);
        tick();
        model_apply(6'h04, 32'h1357_9BDF, 4'hF);
        $display("WR addr=0x04 data=0x13579bdf strb=0xf bresp=0");
        exp_bresp = model_wresp(6'h0C);
        @(negedge clk);
        check("bp_b1_done", bvalid, 0);
        tick();
        @(negedge clk);
        check("bp_b2_valid", bvalid, 1);
        tick();
        model_apply(6'h0C, 32'h2468_ACE0, 4'hF);
        $display("WR addr=0x0c data=0x2468ace0 strb=0xf bresp=0");
        @(negedge clk);
        check("bp_b2_done", bvalid, 0);
        do_read(6'h04, 0, 0, got);
        check("bp_rdata1", got, 32'h1357_9BDF);

        // Commit and AR on the same edge, same register: read sees the old value.
        fork
            do_write(6'h0C, 32'h0BAD_C0DE, 4'hF, 0, 0, 0, resp);
            do_read(6'h0C, 1, 0, got);
        join
        check("same_edge_old", got, 32'h2468_ACE0);
        do_read(6'h0C, 0, 0, got);
        check("same_edge_new", got, 32'h0BAD_C0DE);

        // Randomized traffic.
        for (int t = 0; t < 80; t++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a[AW-1] = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3), resp);
            end else begin
                do_read(a, $urandom_range(0, 2), $urandom_range(0, 3), got);
            end
        end
        read_all();

`ifdef AXIL_WRCOUNT_EN
        do_reset();
        do_write(6'h00, 32'h1, 4'hF, 0, 0, 0, resp);
        do_write(6'h04, 32'h2, 4'hF, 0, 0, 0, resp);
        do_write(6'h08, 32'h3, 4'hF, 0, 0, 0, resp);
        do_write(6'h1C, 32'hFFFF, 4'hF, 0, 0, 0, resp);
        check("cnt_write_slverr", resp, 2'b10);
        do_read(6'h1C, 0, 0, got);
        check("cnt_value", got, 32'd3);
        check("cnt_rresp", rresp, 2'b00);
`endif

        // Reset with only AW buffered: the stale address must not pair with a later W.
        tick();
        awaddr = 6'h00; awvalid = 1'b1;
        @(negedge clk);
        check("mid_aw_ready", awready, 1);
        tick();
        awvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        model_clear();
        wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        check("mid_w_ready", wready, 1);
        tick();
        wvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("mid_no_commit", bvalid, 0);
            check("mid_aw_empty", awready, 1);
            tick();
        end
        do_reset();
        read_all();
        do_read(6'h1C, 0, 0, got);
        check("mid_reg7_zero", got, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axil_regfile_slave.md
# axil_regfile_slave

Parametrised AXI4-Lite slave register file: the next-generation storage endpoint behind the team's AXI4-Lite master. It generalises the fixed 4-entry, 8-bit slave to configurable data width, register count and byte strobes. It adds independent AW/W acceptance in either order, SLVERR for out-of-range addresses, and full valid/ready backpressure on B and R. It connects directly to one AXI4-Lite master inside the top-level wrapper.

## Interface
- DATA_WIDTH, 32: data bus width; power of two, ≥8.
- ADDR_WIDTH, 6: byte-address width.
- NUM_REGS, 8: implemented registers; must satisfy 1 ≤ NUM_REGS ≤ 2^(ADDR_WIDTH−LSB), where LSB = log2(DATA_WIDTH/8).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- awaddr  in  ADDR_WIDTH  write address; awvalid in 1; awready out 1.
- wdata  in  DATA_WIDTH; wstrb in DATA_WIDTH/8  byte enables; wvalid in 1; wready out 1.
- bresp  out  2  00 OKAY, 10 SLVERR; bvalid out 1; bready in 1.
- araddr  in  ADDR_WIDTH; arvalid in 1; arready out 1.
- rdata  out  DATA_WIDTH; rresp out 2; rvalid out 1; rready in 1.

## Operation
- Register index: addr[ADDR_WIDTH−1:LSB]; low LSB bits ignored. Index ≥ NUM_REGS is out of range.
- Write path: separate AW buffer (address) and W buffer (data+strobe), each one entry.
  - awready = AW buffer empty and not rst; wready = W buffer empty and not rst.
  - AW and W accepted in either order or the same cycle.
- Write commit: fires on the edge where both buffers are full and bvalid = 0.
  - In range: for each byte i with wstrb[i]=1, reg[idx] byte i ← wdata byte i; other bytes keep their value. bresp ← 00.
  - Out of range: no storage change; bresp ← 10.
  - On the same edge: bvalid ← 1 and both buffers clear.
- B channel: bvalid held with bresp stable until bvalid∧bready, then bvalid ← 0. No new commit while bvalid = 1, so buffers stay full and awready/wready stay low.
- Read path: arready = ¬rvalid ∧ ¬rst.
  - On AR handshake: rdata ← reg[idx] and rresp ← 00 if in range; otherwise rdata ← 0 and rresp ← 10. rvalid ← 1.
  - rdata/rresp held until rvalid∧rready, then rvalid ← 0.
- Read and write paths are independent. A commit and an AR handshake on the same register in the same edge return the pre-write value.
- wstrb = 0 in range: OKAY, no change.

## Timing
- Reset (async assert, sync-safe deassert):
  - All registers, rdata, bresp, rresp = 0; bvalid = rvalid = 0; buffers empty.
  - awready/wready/arready = 0 while rst = 1 and 1 in the first cycle after release.
- Write latency: bvalid rises on the edge after the later of the AW/W handshakes (1 cycle), provided the previous B was consumed.
- Write throughput: the next AW/W can be accepted the cycle after commit. With bready tied 1, one write per 2 cycles.
- Read latency: rvalid rises on the edge following AR handshake (1 cycle). With rready tied 1, one read per 2 cycles.
- rst mid-transaction: buffered AW/W discarded, pending B/R dropped (valids to 0), registers cleared.

## Configuration
- AXIL_WRCOUNT_EN defined: register NUM_REGS−1 becomes read-only.
  - It holds a DATA_WIDTH-bit count of OKAY write commits, wrapping at 2^DATA_WIDTH.
  - Writes to it return SLVERR and are not counted; reads return the count with OKAY.
  - Reset value 0.
- Macro undefined: all NUM_REGS registers are ordinary read/write; no counter logic.

## Test plan
Defaults DATA_WIDTH=32, ADDR_WIDTH=6, NUM_REGS=8; bready/rready = 1 unless stated.
- Basic write/read: write 0x0000_0004 to awaddr 0x08 with wstrb=F, then read 0x08 → bresp=00; rdata=0x0000_0004, rresp=00, rvalid one cycle after AR.
- Byte strobes: write 0xAABBCCDD to 0x04 with strb F, then 0x11223344 with strb 0x5; read 0x04 → 0xAA22CC44.
- Ordering: W presented 3 cycles before AW, then AW alone → wready drops after W handshake; bvalid one cycle after AW handshake; stored value correct.
- Out of range: write and read address 0x20 (index 8) → bresp=10, rresp=10, rdata=0, registers 0–7 unchanged.
- Backpressure: bready=0 for 5 cycles after a write → bvalid and bresp stable; second AW/W not accepted until B completes. Same check for R with rready=0.
- AXIL_WRCOUNT_EN: 3 OKAY writes plus 1 write to 0x1C → that write gets SLVERR; read 0x1C → 3. Assert rst mid-write → read 0x1C → 0.
